// File: rtl/axis_baser_rx_64.sv
// 10GBASE-R 64b/66b receive framer: decodes start/data/terminate blocks into an
// AXI4-Stream frame, realigning lane-4 starts and holding one beat to place tlast.
module axis_baser_rx_64 #(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH/8,
  parameter int HDR_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] encoded_rx_data,
  input  logic [HDR_WIDTH-1:0]  encoded_rx_hdr,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  start_packet_0,
  output logic                  start_packet_4,
  output logic                  error_bad_block,
  output logic                  error_bad_frame
);

  localparam int HW = DATA_WIDTH/2;

  typedef enum logic [1:0] {IDLE, PAYLOAD, SPILL} state_t;

  state_t                  state, state_d;
  logic [DATA_WIDTH-1:0]   blk_q;
  logic [HDR_WIDTH-1:0]    hdr_q;
  logic                    in_vld;
  logic                    lane4, lane4_d;
  logic [DATA_WIDTH-1:0]   held, held_d;
  logic                    held_vld, held_vld_d;
  logic [HW-1:0]           hi, hi_d;
  logic                    hi_vld, hi_vld_d;
  logic [DATA_WIDTH+HW-1:0] spill_buf, spill_buf_d, term_buf;
  logic [3:0]              spill_cnt, spill_cnt_d, term_cnt;
  logic [DATA_WIDTH-1:0]   tdata_d;
  logic [KEEP_WIDTH-1:0]   tkeep_d;
  logic                    tvalid_d, tlast_d, tuser_d, ebf_d;

  logic [7:0] ctype;
  logic [2:0] term_k;
  logic       is_data, is_ctrl, is_term, is_known, is_start0, is_start4, is_bad;

  function automatic logic [KEEP_WIDTH-1:0] keep_of(input logic [3:0] n);
    return KEEP_WIDTH'((9'd1 << n) - 9'd1);
  endfunction

  always_comb begin
    ctype    = blk_q[7:0];
    is_data  = in_vld && (hdr_q == 2'b01);
    is_ctrl  = in_vld && (hdr_q == 2'b10);
    is_term  = 1'b0;
    is_known = 1'b1;
    term_k   = 3'd0;
    case (ctype)
      8'h87: begin is_term = 1'b1; term_k = 3'd0; end
      8'h99: begin is_term = 1'b1; term_k = 3'd1; end
      8'hAA: begin is_term = 1'b1; term_k = 3'd2; end
      8'hB4: begin is_term = 1'b1; term_k = 3'd3; end
      8'hCC: begin is_term = 1'b1; term_k = 3'd4; end
      8'hD2: begin is_term = 1'b1; term_k = 3'd5; end
      8'hE1: begin is_term = 1'b1; term_k = 3'd6; end
      8'hFF: begin is_term = 1'b1; term_k = 3'd7; end
      8'h78, 8'h33, 8'h66, 8'h1E, 8'h2D, 8'h4B, 8'h55: ;
      default: is_known = 1'b0;
    endcase
    is_term   = is_term && is_ctrl;
    is_start0 = is_ctrl && (ctype == 8'h78);
    is_start4 = is_ctrl && (ctype == 8'h33 || ctype == 8'h66);
    is_bad    = in_vld && (hdr_q == 2'b00 || hdr_q == 2'b11 || (is_ctrl && !is_known));
    // Bytes left after the last full beat: terminate octets, behind any pending lane-4 half.
    term_cnt  = {1'b0, term_k} + (hi_vld ? 4'd4 : 4'd0);
    term_buf  = hi_vld ? {8'h00, blk_q[63:8], hi} : {40'h0, blk_q[63:8]};
  end

  always_comb begin
    state_d     = state;
    lane4_d     = lane4;
    held_d      = held;
    held_vld_d  = held_vld;
    hi_d        = hi;
    hi_vld_d    = hi_vld;
    spill_buf_d = spill_buf;
    spill_cnt_d = spill_cnt;
    tdata_d     = '0;
    tkeep_d     = '0;
    tvalid_d    = 1'b0;
    tlast_d     = 1'b0;
    tuser_d     = 1'b0;
    ebf_d       = 1'b0;
    case (state)
      IDLE: ;
      PAYLOAD: begin
        if (is_data) begin
          if (held_vld) begin
            tvalid_d = 1'b1; tdata_d = held; tkeep_d = '1;
          end
          if (lane4) begin
            // First data block after a lane-4 start only supplies the upper half.
            held_vld_d = hi_vld;
            held_d     = {blk_q[HW-1:0], hi};
            hi_d       = blk_q[DATA_WIDTH-1:HW];
            hi_vld_d   = 1'b1;
          end else begin
            held_d     = blk_q;
            held_vld_d = 1'b1;
          end
        end else if (is_term) begin
          if (held_vld) begin
            tvalid_d = 1'b1; tdata_d = held; tkeep_d = '1;
            tlast_d  = (term_cnt == 4'd0);
          end
          spill_buf_d = term_buf;
          spill_cnt_d = term_cnt;
          held_vld_d  = 1'b0;
          hi_vld_d    = 1'b0;
          state_d     = (term_cnt == 4'd0) ? IDLE : SPILL;
        end else begin
          tvalid_d = 1'b1; tlast_d = 1'b1; tuser_d = 1'b1; ebf_d = 1'b1;
          if (held_vld) begin
            tdata_d = held; tkeep_d = '1;
          end else if (hi_vld) begin
            tdata_d = {{HW{1'b0}}, hi}; tkeep_d = 8'h0F;
          end else begin
            tkeep_d = 8'h01;
          end
          held_vld_d = 1'b0;
          hi_vld_d   = 1'b0;
          state_d    = IDLE;
        end
      end
      SPILL: begin
        tvalid_d = 1'b1;
        tdata_d  = spill_buf[DATA_WIDTH-1:0];
        if (spill_cnt > 4'd8) begin
          tkeep_d     = '1;
          spill_buf_d = {{DATA_WIDTH{1'b0}}, spill_buf[DATA_WIDTH+HW-1:DATA_WIDTH]};
          spill_cnt_d = spill_cnt - 4'd8;
        end else begin
          tkeep_d = keep_of(spill_cnt);
          tlast_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A start block opens a new frame wherever the previous one has just ended.
    if ((is_start0 || is_start4) && (state_d == IDLE || (state == PAYLOAD && !is_data && !is_term))) begin
      state_d    = PAYLOAD;
      lane4_d    = is_start4;
      held_vld_d = 1'b0;
      hi_vld_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      blk_q           <= '0;
      hdr_q           <= '0;
      in_vld          <= 1'b0;
      lane4           <= 1'b0;
      held            <= '0;
      held_vld        <= 1'b0;
      hi              <= '0;
      hi_vld          <= 1'b0;
      spill_buf       <= '0;
      spill_cnt       <= '0;
      m_axis_tdata    <= '0;
      m_axis_tkeep    <= '0;
      m_axis_tvalid   <= 1'b0;
      m_axis_tlast    <= 1'b0;
      m_axis_tuser    <= 1'b0;
      start_packet_0  <= 1'b0;
      start_packet_4  <= 1'b0;
      error_bad_block <= 1'b0;
      error_bad_frame <= 1'b0;
    end else begin
      state           <= state_d;
      blk_q           <= encoded_rx_data;
      hdr_q           <= encoded_rx_hdr;
      in_vld          <= 1'b1;
      lane4           <= lane4_d;
      held            <= held_d;
      held_vld        <= held_vld_d;
      hi              <= hi_d;
      hi_vld          <= hi_vld_d;
      spill_buf       <= spill_buf_d;
      spill_cnt       <= spill_cnt_d;
      m_axis_tdata    <= tdata_d;
      m_axis_tkeep    <= tkeep_d;
      m_axis_tvalid   <= tvalid_d;
      m_axis_tlast    <= tlast_d;
      m_axis_tuser    <= tuser_d;
      start_packet_0  <= is_start0;
      start_packet_4  <= is_start4;
      error_bad_block <= is_bad;
      error_bad_frame <= ebf_d;
    end
  end

endmodule
